// File: rtl/regfile_ic_pkg.sv
// Shared types and helpers for the intermittent-computing register file.
package regfile_ic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BKP,
        ST_BKP_DONE,
        ST_RSTR_REQ,
        ST_RSTR_WAIT,
        ST_RSTR_DONE
    } state_t;

    // Upper bound on M; narrower dirty vectors are zero-extended by callers.
    localparam int unsigned MAX_REGS = 1024;

    function automatic int unsigned addr_w(input int unsigned m);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_REGS; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile_ic_fsm.sv
// Backup/restore sequencer: walks ptr across the file, drives the NVM handshakes.
module regfile_ic_fsm
    import regfile_ic_pkg::*;
#(
    parameter int unsigned M        = 32,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = addr_w(M)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bkp_req,
    input  logic          bkp_ready,
    input  logic          rstr_req,
    input  logic          rstr_valid,
    input  logic [M-1:0]  dirty_next,
    output logic          busy,
    output logic [AW-1:0] ptr,
    output logic          bkp_valid,
    output logic [AW-1:0] bkp_addr,
    output logic          bkp_done,
    output logic          rstr_rd,
    output logic [AW-1:0] rstr_addr,
    output logic          rstr_done,
    output logic          bkp_fire,
    output logic          rstr_load
);

    localparam logic [AW-1:0] START = ZERO_REG ? AW'(1) : AW'(0);
    localparam logic [AW-1:0] LAST  = AW'(M - 1);

    state_t        state;
    logic [AW-1:0] ptr_inc;

    assign ptr_inc   = ptr + AW'(1);
    assign bkp_fire  = (state == ST_BKP) && bkp_valid && bkp_ready;
    assign rstr_load = (state == ST_RSTR_WAIT) && rstr_valid;

    // bkp_valid is registered, so it is loaded with the dirty bit of the
    // register ptr is about to point at (dirty_next covers a same-edge write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            busy      <= 1'b0;
            bkp_valid <= 1'b0;
            bkp_addr  <= '0;
            bkp_done  <= 1'b0;
            rstr_rd   <= 1'b0;
            rstr_addr <= '0;
            rstr_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bkp_req) begin
                        state     <= ST_BKP;
                        ptr       <= START;
                        busy      <= 1'b1;
                        bkp_valid <= dirty_next[START];
                        bkp_addr  <= START;
                    end else if (rstr_req) begin
                        state     <= ST_RSTR_REQ;
                        ptr       <= START;
                        busy      <= 1'b1;
                        rstr_rd   <= 1'b1;
                        rstr_addr <= START;
                    end
                end
                ST_BKP: begin
                    if (!bkp_valid || bkp_ready) begin
                        if (ptr == LAST) begin
                            state     <= ST_BKP_DONE;
                            bkp_valid <= 1'b0;
                            bkp_done  <= 1'b1;
                        end else begin
                            ptr       <= ptr_inc;
                            bkp_valid <= dirty_next[ptr_inc];
                            bkp_addr  <= ptr_inc;
                        end
                    end
                end
                ST_BKP_DONE: begin
                    if (!bkp_req) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        bkp_done <= 1'b0;
                    end
                end
                ST_RSTR_REQ: begin
                    state   <= ST_RSTR_WAIT;
                    rstr_rd <= 1'b0;
                end
                ST_RSTR_WAIT: begin
                    if (rstr_valid) begin
                        if (ptr == LAST) begin
                            state     <= ST_RSTR_DONE;
                            rstr_done <= 1'b1;
                        end else begin
                            state     <= ST_RSTR_REQ;
                            ptr       <= ptr_inc;
                            rstr_rd   <= 1'b1;
                            rstr_addr <= ptr_inc;
                        end
                    end
                end
                ST_RSTR_DONE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    rstr_done <= 1'b0;
                    rstr_addr <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_ic_seq.sv
// Multi-port register file with dirty tracking and an integrated NVM
// backup/restore sequencer.
module regfile_ic_seq
    import regfile_ic_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned M        = 32,
    parameter int unsigned R        = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = addr_w(M)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            WEn,
    input  logic [AW-1:0]   AddrWrite,
    input  logic [N-1:0]    Write,
    input  logic [R-1:0]    Rd_ens,
    input  logic [R*AW-1:0] Rd_addrs,
    output logic [R*N-1:0]  Rd_data,
    input  logic            Bkp_req,
    output logic            Bkp_valid,
    output logic [AW-1:0]   Bkp_addr,
    output logic [N-1:0]    Bkp_data,
    input  logic            Bkp_ready,
    output logic            Bkp_done,
    input  logic            Rstr_req,
    output logic            Rstr_rd,
    output logic [AW-1:0]   Rstr_addr,
    input  logic            Rstr_valid,
    input  logic [N-1:0]    Rstr_data,
    output logic            Rstr_done,
    output logic            Busy,
    output logic            Wr_drop,
    output logic [AW:0]     Dirty_cnt
);

    logic [N-1:0]  regs [M];
    logic [M-1:0]  dirty;
    logic [M-1:0]  dirty_next;
    logic [AW-1:0] ptr;
    logic          bkp_fire;
    logic          rstr_load;
    logic          write_hit;
    logic          write_ok;
    logic [AW-1:0] rd_addr;

    regfile_ic_fsm #(
        .M        (M),
        .ZERO_REG (ZERO_REG)
    ) u_fsm (
        .clk        (Clk),
        .rst_n      (Rst),
        .bkp_req    (Bkp_req),
        .bkp_ready  (Bkp_ready),
        .rstr_req   (Rstr_req),
        .rstr_valid (Rstr_valid),
        .dirty_next (dirty_next),
        .busy       (Busy),
        .ptr        (ptr),
        .bkp_valid  (Bkp_valid),
        .bkp_addr   (Bkp_addr),
        .bkp_done   (Bkp_done),
        .rstr_rd    (Rstr_rd),
        .rstr_addr  (Rstr_addr),
        .rstr_done  (Rstr_done),
        .bkp_fire   (bkp_fire),
        .rstr_load  (rstr_load)
    );

    assign write_hit = WEn && !(ZERO_REG && (AddrWrite == '0));
    assign write_ok  = write_hit && !Busy;

    always_comb begin
        dirty_next = dirty;
        if (write_ok) dirty_next[AddrWrite] = 1'b1;
        if (bkp_fire || rstr_load) dirty_next[ptr] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < M; i++) regs[i] <= '0;
        end else if (write_ok) begin
            regs[AddrWrite] <= Write;
        end else if (rstr_load) begin
            regs[ptr] <= Rstr_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            dirty     <= '0;
            Dirty_cnt <= '0;
            Wr_drop   <= 1'b0;
        end else begin
            dirty     <= dirty_next;
            Dirty_cnt <= (AW+1)'(popcount(MAX_REGS'(dirty_next)));
            Wr_drop   <= write_hit && Busy;
        end
    end

    // Writes are frozen while the sequencer runs, so the word stays stable.
    assign Bkp_data = Bkp_valid ? regs[Bkp_addr] : '0;

    always_comb begin
        Rd_data = '0;
        rd_addr = '0;
        for (int unsigned k = 0; k < R; k++) begin
            rd_addr = Rd_addrs[k*AW +: AW];
            if (Rd_ens[k] && !(ZERO_REG && (rd_addr == '0)))
                Rd_data[k*N +: N] = regs[rd_addr];
        end
    end

endmodule

// File: tb/tb_regfile_ic_seq.sv
// Scoreboard bench for regfile_ic_seq with an NVM responder and reference model.
module tb_regfile_ic_seq;

    localparam int unsigned N  = 32;
    localparam int unsigned M  = 32;
    localparam int unsigned R  = 2;
    localparam int unsigned AW = 5;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            WEn;
    logic [AW-1:0]   AddrWrite;
    logic [N-1:0]    Write;
    logic [R-1:0]    Rd_ens;
    logic [R*AW-1:0] Rd_addrs;
    logic [R*N-1:0]  Rd_data;
    logic            Bkp_req;
    logic            Bkp_valid;
    logic [AW-1:0]   Bkp_addr;
    logic [N-1:0]    Bkp_data;
    logic            Bkp_ready;
    logic            Bkp_done;
    logic            Rstr_req;
    logic            Rstr_rd;
    logic [AW-1:0]   Rstr_addr;
    logic            Rstr_valid;
    logic [N-1:0]    Rstr_data;
    logic            Rstr_done;
    logic            Busy;
    logic            Wr_drop;
    logic [AW:0]     Dirty_cnt;

    regfile_ic_seq #(.N(N), .M(M), .R(R), .ZERO_REG(1'b1)) dut (
        .Clk(Clk), .Rst(Rst), .WEn(WEn), .AddrWrite(AddrWrite), .Write(Write),
        .Rd_ens(Rd_ens), .Rd_addrs(Rd_addrs), .Rd_data(Rd_data),
        .Bkp_req(Bkp_req), .Bkp_valid(Bkp_valid), .Bkp_addr(Bkp_addr),
        .Bkp_data(Bkp_data), .Bkp_ready(Bkp_ready), .Bkp_done(Bkp_done),
        .Rstr_req(Rstr_req), .Rstr_rd(Rstr_rd), .Rstr_addr(Rstr_addr),
        .Rstr_valid(Rstr_valid), .Rstr_data(Rstr_data), .Rstr_done(Rstr_done),
        .Busy(Busy), .Wr_drop(Wr_drop), .Dirty_cnt(Dirty_cnt)
    );

    always #5 Clk = ~Clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [N-1:0] mregs [M];
    bit           mdirty[M];
    logic [N-1:0] nvm   [M];

    typedef struct {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } bkp_t;

    bkp_t        bkp_q[$];
    int unsigned rstr_q[$];
    bit          noise = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned model_cnt();
        int unsigned c = 0;
        for (int i = 0; i < M; i++) if (mdirty[i]) c++;
        return c;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_write(input int unsigned a, input logic [N-1:0] d);
        WEn = 1'b1; AddrWrite = AW'(a); Write = d;
        tick();
        WEn = 1'b0;
        if (a != 0) begin
            mregs[a] = d;
            mdirty[a] = 1'b1;
        end
        check("dirty_cnt_after_write", Dirty_cnt, model_cnt());
        check("wr_drop_idle", Wr_drop, 0);
    endtask

    task automatic check_read(input int unsigned a0, input int unsigned a1, input logic [1:0] en);
        logic [N-1:0] exp;
        int unsigned  a;
        Rd_ens = en;
        Rd_addrs = {AW'(a1), AW'(a0)};
        #1;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? a0 : a1;
            exp = (en[k] && a != 0) ? mregs[a] : '0;
            check($sformatf("rd_port%0d_addr%0d", k, a), Rd_data[k*N +: N], exp);
        end
    endtask

    task automatic load_bkp_queue();
        bkp_t e;
        bkp_q.delete();
        for (int i = 1; i < M; i++) begin
            if (mdirty[i]) begin
                e.addr = AW'(i);
                e.data = mregs[i];
                bkp_q.push_back(e);
            end
        end
    endtask

    task automatic finish_backup_model();
        for (int i = 0; i < M; i++) mdirty[i] = 1'b0;
    endtask

    task automatic run_restore();
        int unsigned pulses;
        bit          seen;
        rstr_q.delete();
        for (int i = 1; i < M; i++) rstr_q.push_back(i);
        Rstr_req = 1'b1;
        tick();
        check("rstr_busy", Busy, 1);
        Rstr_req = 1'b0;
        pulses = 0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            tick();
            if (Rstr_done) begin
                seen = 1'b1;
                pulses++;
            end
        end
        check("rstr_done_seen", seen, 1);
        repeat (3) begin
            tick();
            if (Rstr_done) pulses++;
        end
        check("rstr_done_pulses", pulses, 1);
        check("rstr_idle", Busy, 0);
        check("rstr_q_empty", rstr_q.size(), 0);
        for (int i = 1; i < M; i++) begin
            mregs[i] = nvm[i];
            mdirty[i] = 1'b0;
        end
        check("rstr_dirty_cnt", Dirty_cnt, 0);
    endtask

    // Backup scoreboard: every presented word must match the next expected one.
    always @(negedge Clk) begin
        if (Rst && Bkp_valid) begin
            if (bkp_q.size() == 0) begin
                check("bkp_unexpected_word", Bkp_valid, 0);
            end else begin
                check("bkp_addr", Bkp_addr, bkp_q[0].addr);
                check("bkp_data", Bkp_data, bkp_q[0].data);
                if (Bkp_ready) void'(bkp_q.pop_front());
            end
        end
    end

    // NVM restore responder: answers each read two cycles later.
    initial begin
        logic [AW-1:0] a;
        Rstr_valid = 1'b0;
        Rstr_data = '0;
        forever begin
            @(posedge Clk);
            #1;
            Rstr_valid = 1'b0;
            if (Rst && Rstr_rd) begin
                a = Rstr_addr;
                if (rstr_q.size() == 0) check("rstr_unexpected_rd", Rstr_rd, 0);
                else check("rstr_addr", a, rstr_q.pop_front());
                repeat (2) @(posedge Clk);
                #1;
                Rstr_valid = 1'b1;
                Rstr_data = nvm[a];
            end else if (noise) begin
                Rstr_valid = 1'($urandom_range(0, 1));
                Rstr_data = $urandom;
            end
        end
    end

    initial begin
        bit done;
        for (int i = 0; i < M; i++) begin
            mregs[i] = '0; mdirty[i] = 1'b0; nvm[i] = '0;
        end
        Rst = 1'b0; WEn = 1'b0; AddrWrite = '0; Write = '0;
        Rd_ens = '0; Rd_addrs = '0;
        Bkp_req = 1'b0; Bkp_ready = 1'b0; Rstr_req = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;

        check_read(5, 31, 2'b11);
        check("reset_dirty_cnt", Dirty_cnt, 0);
        check("reset_busy", Busy, 0);
        check("reset_bkp_valid", Bkp_valid, 0);
        check("reset_bkp_done", Bkp_done, 0);
        check("reset_rstr_rd", Rstr_rd, 0);

        do_write(3, 32'hDEADBEEF);
        do_write(7, 32'h0000_1234);
        do_write(0, 32'hFFFF_FFFF);
        check_read(3, 7, 2'b11);
        check_read(0, 7, 2'b01);
        check("two_dirty", Dirty_cnt, 2);

        // Backup with ready stall and a dropped write.
        load_bkp_queue();
        Bkp_req = 1'b1; Bkp_ready = 1'b0;
        tick();
        check("bkp_busy", Busy, 1);
        WEn = 1'b1; AddrWrite = AW'(9); Write = 32'hCAFE_F00D;
        tick();
        WEn = 1'b0;
        check("wr_drop_pulse", Wr_drop, 1);
        tick();
        check("wr_drop_clear", Wr_drop, 0);
        repeat (3) tick();
        Bkp_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            done = Bkp_done;
        end
        check("bkp_done_seen", done, 1);
        check("bkp_q_empty", bkp_q.size(), 0);
        finish_backup_model();
        check("bkp_dirty_cnt", Dirty_cnt, 0);
        Bkp_ready = 1'b0;
        repeat (2) begin
            tick();
            check("bkp_done_held", Bkp_done, 1);
        end
        Bkp_req = 1'b0;
        tick();
        check("bkp_done_release", Bkp_done, 0);
        check("bkp_idle", Busy, 0);
        check_read(9, 3, 2'b11);

        for (int i = 0; i < M; i++) nvm[i] = N'(i) * 32'h11;
        run_restore();
        check_read(31, 1, 2'b11);

        // Random traffic with spurious restore data that must be ignored.
        noise = 1'b1;
        for (int i = 0; i < 30; i++) do_write($urandom_range(0, M-1), $urandom);
        for (int i = 0; i < 10; i++)
            check_read($urandom_range(0, M-1), $urandom_range(0, M-1), 2'($urandom_range(0, 3)));
        noise = 1'b0;
        tick();
        WEn = 1'b1; AddrWrite = AW'(12); Write = 32'h5A5A_0012;
        check_read(12, 12, 2'b11);
        tick();
        WEn = 1'b0;
        mregs[12] = 32'h5A5A_0012; mdirty[12] = 1'b1;
        check_read(12, 3, 2'b11);
        check("rand_dirty_cnt", Dirty_cnt, model_cnt());

        // Backup with random ready and request dropped mid-scan.
        load_bkp_queue();
        Bkp_req = 1'b1;
        tick();
        WEn = 1'b1; AddrWrite = '0; Write = 32'h1;
        tick();
        WEn = 1'b0;
        check("wr_drop_zero_reg", Wr_drop, 0);
        repeat (3) begin
            Bkp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        Bkp_req = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            Bkp_ready = 1'($urandom_range(0, 1));
            tick();
            done = Bkp_done;
        end
        check("bkp2_done_seen", done, 1);
        check("bkp2_busy_at_done", Busy, 1);
        tick();
        check("bkp2_idle", Busy, 0);
        check("bkp2_done_clear", Bkp_done, 0);
        check("bkp2_q_empty", bkp_q.size(), 0);
        finish_backup_model();
        check("bkp2_dirty_cnt", Dirty_cnt, 0);
        Bkp_ready = 1'b0;

        for (int i = 0; i < M; i++) nvm[i] = $urandom;
        run_restore();
        for (int i = 0; i < 6; i++) check_read($urandom_range(0, M-1), $urandom_range(0, M-1), 2'b11);

        // Priority and asynchronous reset mid-backup.
        do_write(2, $urandom);
        do_write(20, $urandom);
        do_write(31, $urandom);
        load_bkp_queue();
        Bkp_req = 1'b1; Rstr_req = 1'b1; Bkp_ready = 1'b0;
        tick();
        check("prio_busy", Busy, 1);
        check("prio_no_rstr_rd", Rstr_rd, 0);
        Bkp_ready = 1'b1;
        repeat (4) tick();
        check("prio_bkp_not_done", Bkp_done, 0);
        #2;
        Rst = 1'b0;
        #1;
        check("arst_busy", Busy, 0);
        check("arst_bkp_valid", Bkp_valid, 0);
        check("arst_bkp_data", Bkp_data, 0);
        check("arst_bkp_addr", Bkp_addr, 0);
        check("arst_dirty_cnt", Dirty_cnt, 0);
        check("arst_rstr_rd", Rstr_rd, 0);
        check("arst_rstr_addr", Rstr_addr, 0);
        for (int i = 0; i < M; i++) begin
            mregs[i] = '0; mdirty[i] = 1'b0;
        end
        check_read(2, 20, 2'b11);
        Bkp_req = 1'b0; Rstr_req = 1'b0; Bkp_ready = 1'b0;
        bkp_q.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        tick();
        check("post_reset_busy", Busy, 0);
        check_read(31, 7, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
